wb_stage_multislot: RTL

Parametrised successor to the single-slot writeback stage of the LoongArch pipeline. It accepts a bundle of up to NSLOT retiring instructions from the ME stage under a valid/allowin handshake. It drives NSLOT register-file write ports and serialises every retired slot through a debug-trace FIFO onto the single debug_wb_* port, one entry per cycle. Backpressure and WB-stage flush are new behaviour.

---
 rtl/wb_stage_multislot.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/wb_stage_multislot.sv
// Multi-slot writeback stage: NSLOT register-file write ports plus a trace FIFO
// that serialises every retired slot onto the single debug_wb_* port.
module wb_stage_multislot #(
    parameter int NSLOT     = 2,
    parameter int PC_W      = 32,
    parameter int DATA_W    = 32,
    parameter int DBG_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ME_Valid,
    input  logic [NSLOT-1:0]                  ME_Slot_Valid,
    input  logic [NSLOT*(PC_W+6+DATA_W)-1:0]  ME_to_WB_Bus,
    input  logic                              WB_Flush,
    output logic                              WB_Allowin,
    output logic [NSLOT*(6+DATA_W)-1:0]       WB_to_RF_Bus,
    output logic [PC_W-1:0]                   debug_wb_pc,
    output logic [3:0]                        debug_wb_rf_we,
    output logic [4:0]                        debug_wb_rf_wnum,
    output logic [DATA_W-1:0]                 debug_wb_rf_wdata
);
    localparam int SLOT_W = PC_W + 6 + DATA_W;
    localparam int RF_W   = 6 + DATA_W;
    localparam int AW     = $clog2(DBG_DEPTH);
    localparam int CW     = AW + 1;
    localparam int PW     = $clog2(NSLOT + 1);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              we;
        logic [4:0]        dest;
        logic [DATA_W-1:0] data;
    } trace_t;

    logic                       wb_valid_q, wb_valid_d, accept;
    logic [NSLOT-1:0]           slot_vld_q;
    logic [NSLOT*SLOT_W-1:0]    bus_q;

    logic [NSLOT-1:0][PC_W-1:0]   s_pc;
    logic [NSLOT-1:0]             s_gwe;
    logic [NSLOT-1:0][4:0]        s_dest;
    logic [NSLOT-1:0][DATA_W-1:0] s_res;
    logic [NSLOT-1:0]             live, wr, rf_we;

    trace_t [NSLOT-1:0] push_ent;
    logic [PW-1:0]      npush;

    trace_t          mem_q [DBG_DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d, rem;
    logic            pop;
    trace_t          dbg_q, nxt;
    int              pend;

    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            s_pc[i]   = bus_q[i*SLOT_W + 6 + DATA_W +: PC_W];
            s_gwe[i]  = bus_q[i*SLOT_W + 5 + DATA_W];
            s_dest[i] = bus_q[i*SLOT_W + DATA_W +: 5];
            s_res[i]  = bus_q[i*SLOT_W +: DATA_W];
            live[i]   = wb_valid_q && slot_vld_q[i] && !WB_Flush;
            wr[i]     = live[i] && s_gwe[i] && (s_dest[i] != 5'd0);
        end
    end

    // Youngest slot wins a same-destination conflict; the trace still sees both.
    always_comb begin
        WB_to_RF_Bus = '0;
        for (int i = 0; i < NSLOT; i++) begin
            rf_we[i] = wr[i];
            for (int j = i + 1; j < NSLOT; j++)
                if (wr[j] && (s_dest[j] == s_dest[i])) rf_we[i] = 1'b0;
            WB_to_RF_Bus[i*RF_W +: RF_W] = {rf_we[i], s_dest[i], s_res[i]};
        end
    end

    always_comb begin
        int k;
        k        = 0;
        push_ent = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (live[i]) begin
                push_ent[k] = '{pc: s_pc[i], we: s_gwe[i] && (s_dest[i] != 5'd0),
                                dest: s_dest[i], data: s_res[i]};
                k = k + 1;
            end
        end
        npush = PW'(k);
    end

    always_comb begin
        pend = 0;
        if (wb_valid_q)
            for (int i = 0; i < NSLOT; i++) pend = pend + int'(slot_vld_q[i]);
        WB_Allowin = (DBG_DEPTH - int'(cnt_q) - pend) >= NSLOT;
        accept     = ME_Valid && WB_Allowin;
        wb_valid_d = accept;
    end

    // The debug register is loaded with whatever will be at the FIFO head next
    // cycle, so a freshly pushed entry is visible one cycle after its WB cycle.
    always_comb begin
        pop      = (cnt_q != '0);
        cnt_d    = cnt_q - CW'(pop) + CW'(npush);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(npush);
        rem      = cnt_q - CW'(pop);
        if (rem != '0) nxt = mem_q[rd_ptr_d];
        else           nxt = push_ent[0];
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NSLOT; k++)
            if (k < int'(npush)) mem_q[wr_ptr_q + AW'(k)] <= push_ent[k];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            slot_vld_q <= '0;
            bus_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            dbg_q      <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            if (accept) begin
                slot_vld_q <= ME_Slot_Valid;
                bus_q      <= ME_to_WB_Bus;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            if (cnt_d != '0) dbg_q <= nxt;
        end
    end

    assign debug_wb_pc       = dbg_q.pc;
    assign debug_wb_rf_we    = {4{(cnt_q != '0) && dbg_q.we}};
    assign debug_wb_rf_wnum  = dbg_q.dest;
    assign debug_wb_rf_wdata = dbg_q.data;

endmodule
